// File: rtl/light_hash_iter.sv
// light_hash_iter: iterative AES-S-box hash over a byte stream, one round per clock.
// Define LH_TWO_ROUNDS_EN to apply two chained rounds per clock (ROUNDS must be even).
module light_hash_iter #(
    parameter int N_BLOCKS = 8,
    parameter int ROUNDS = 32,
    parameter logic [N_BLOCKS*8-1:0] INIT_VALUE = 64'h34550F14DAC02BEE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  msg_valid,
    output logic                  msg_ready,
    input  logic [7:0]            msg_byte,
    input  logic                  msg_last,
    output logic                  digest_valid,
    input  logic                  digest_ready,
    output logic [N_BLOCKS*8-1:0] digest,
    output logic                  busy
);
    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    if (ROUNDS < 1 || ROUNDS > 255 || N_BLOCKS < 2 || N_BLOCKS > 32) begin : g_bad_param
        $fatal(1, "light_hash_iter: illegal ROUNDS or N_BLOCKS");
    end

    typedef enum logic [1:0] {IDLE, WAIT, ROUND, OUTPUT} state_t;

    state_t                  state, state_d;
    logic [N_BLOCKS*8-1:0]   h, h_next;
    logic [7:0]              m;
    logic [7:0]              cnt;
    logic                    last;
    logic                    accept;
    logic                    done;

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[{x, 3'b000} +: 8];
    endfunction

    // Every lane reads the old H, so all lanes update in parallel.
    function automatic logic [N_BLOCKS*8-1:0] round_f(input logic [N_BLOCKS*8-1:0] hin, input logic [7:0] mb);
        logic [N_BLOCKS*8-1:0] r;
        logic [15:0]           rot;
        r = '0;
        for (int j = 0; j < N_BLOCKS; j++) begin
            rot = {2{hin[(N_BLOCKS-1-((j+2)%N_BLOCKS))*8 +: 8] ^ mb}} << (j % 8);
            r[(N_BLOCKS-1-j)*8 +: 8] = sbox(rot[15:8]);
        end
        return r;
    endfunction

`ifdef LH_TWO_ROUNDS_EN
    localparam int STEP = 2;
    if (ROUNDS % 2 != 0) begin : g_bad_rounds
        $fatal(1, "light_hash_iter: ROUNDS must be even with LH_TWO_ROUNDS_EN");
    end
    assign h_next = round_f(round_f(h, m), m);
`else
    localparam int STEP = 1;
    assign h_next = round_f(h, m);
`endif

    assign accept = msg_valid && msg_ready;
    assign done   = cnt == 8'(ROUNDS - STEP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE, WAIT: state_d = msg_valid ? ROUND : state;
            ROUND:      state_d = done ? (last ? OUTPUT : WAIT) : ROUND;
            OUTPUT:     state_d = digest_ready ? IDLE : OUTPUT;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        msg_ready    = state == IDLE || state == WAIT;
        digest_valid = state == OUTPUT;
        digest       = digest_valid ? h : '0;
        busy         = state != IDLE;
    end

    // A new message restarts from INIT_VALUE; later bytes chain on the running H.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h    <= INIT_VALUE;
            m    <= '0;
            last <= 1'b0;
            cnt  <= '0;
        end else if (accept) begin
            h    <= state == IDLE ? INIT_VALUE : h;
            m    <= msg_byte;
            last <= msg_last;
            cnt  <= '0;
        end else if (state == ROUND) begin
            h    <= h_next;
            cnt  <= cnt + 8'(STEP);
        end
    end
endmodule

// File: tb/tb_light_hash_iter.sv
// tb_light_hash_iter: random and directed byte messages checked against a transaction-level model
// whose S-box is derived from GF(2^8) inversion plus the AES affine map.
module tb_light_hash_iter;
    localparam int R = 32;
`ifdef LH_TWO_ROUNDS_EN
    localparam int RPE = 2;
    localparam int R1 = 2;
`else
    localparam int RPE = 1;
    localparam int R1 = 1;
`endif
    localparam int LAT = R / RPE;
    localparam logic [63:0] INIT = 64'h34550F14DAC02BEE;

    logic clk = 0, rst_n = 0;
    logic msg_valid = 0, msg_last = 0, digest_ready = 0;
    logic [7:0] msg_byte = 0;
    logic msg_ready, digest_valid, busy;
    logic [63:0] digest;

    logic v1 = 0, l1 = 0, dr1 = 0;
    logic [7:0] b1 = 0;
    logic rdy1, dv1, busy1;
    logic [63:0] dig1;

    int checks = 0, fails = 0;
    logic [7:0] sb [256];

    always #5 clk = ~clk;

    light_hash_iter #(.N_BLOCKS(8), .ROUNDS(R), .INIT_VALUE(INIT)) u_dut (
        .clk(clk), .rst_n(rst_n), .msg_valid(msg_valid), .msg_ready(msg_ready),
        .msg_byte(msg_byte), .msg_last(msg_last), .digest_valid(digest_valid),
        .digest_ready(digest_ready), .digest(digest), .busy(busy));

    light_hash_iter #(.N_BLOCKS(8), .ROUNDS(R1), .INIT_VALUE(INIT)) u_r1 (
        .clk(clk), .rst_n(rst_n), .msg_valid(v1), .msg_ready(rdy1),
        .msg_byte(b1), .msg_last(l1), .digest_valid(dv1),
        .digest_ready(dr1), .digest(dig1), .busy(busy1));

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        p = 0;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rl8(input logic [7:0] b, input int k);
        logic [15:0] t;
        t = {b, b} << k;
        return t[15:8];
    endfunction

    function automatic logic [63:0] absorb(input logic [63:0] h, input logic [7:0] m, input int rounds);
        logic [7:0] a [8];
        logic [7:0] n [8];
        logic [63:0] r;
        for (int j = 0; j < 8; j++) a[j] = h[(7-j)*8 +: 8];
        for (int k = 0; k < rounds; k++) begin
            for (int j = 0; j < 8; j++) n[j] = sb[rl8(a[(j+2)%8] ^ m, j%8)];
            a = n;
        end
        for (int j = 0; j < 8; j++) r[(7-j)*8 +: 8] = a[j];
        return r;
    endfunction

    function automatic logic [63:0] fold(input logic [7:0] q[$]);
        logic [63:0] h;
        h = INIT;
        foreach (q[i]) h = absorb(h, q[i], R);
        return h;
    endfunction

    // Transaction model: accepted byte hashes instantly; outputs reflect it after LAT edges.
    int cyc_left = 0;
    logic pend_last = 0, out_pend = 0, in_msg = 0;
    logic [63:0] mh = INIT;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_left <= 0; pend_last <= 0; out_pend <= 0; in_msg <= 0; mh <= INIT;
        end else if (cyc_left > 0) begin
            cyc_left <= cyc_left - 1;
            if (cyc_left == 1 && pend_last) out_pend <= 1;
        end else if (out_pend) begin
            if (digest_ready) begin out_pend <= 0; in_msg <= 0; end
        end else if (msg_valid) begin
            mh <= absorb(in_msg ? mh : INIT, msg_byte, R);
            in_msg <= 1; cyc_left <= LAT; pend_last <= msg_last;
        end
    end

    always @(negedge clk) begin
        logic er, ev;
        er = cyc_left == 0 && !out_pend;
        ev = cyc_left == 0 && out_pend;
        chk("msg_ready", 64'(msg_ready), 64'(er));
        chk("digest_valid", 64'(digest_valid), 64'(ev));
        chk("digest", digest, ev ? mh : 64'h0);
        chk("busy", 64'(busy), 64'(in_msg));
    end

    task automatic send(input logic [7:0] b, input logic l);
        logic r;
        int t;
        msg_valid = 1; msg_byte = b; msg_last = l; digest_ready = 1'($urandom_range(0, 1)); t = 0;
        do begin
            @(negedge clk); r = msg_ready;
            @(posedge clk); #1; t++;
        end while (!r && t < 300);
        chk("accept_wait", 64'(r), 64'h1);
        msg_valid = 0; msg_byte = 8'($urandom); msg_last = 1'($urandom_range(0, 1)); digest_ready = 0;
    endtask

    task automatic get_digest(input int hold, output logic [63:0] d, output int t);
        logic v;
        digest_ready = 0; t = 0;
        do begin
            @(negedge clk); v = digest_valid;
            if (!v) begin @(posedge clk); #1; t++; end
        end while (!v && t < 300);
        chk("digest_wait", 64'(v), 64'h1);
        d = digest;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1; @(negedge clk);
            chk("bp_valid", 64'(digest_valid), 64'h1);
            chk("bp_stable", digest, d);
        end
        digest_ready = 1;
        @(posedge clk); #1;
        digest_ready = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] d1, d2, exp;
        logic [7:0] q[$];
        int t, len;
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv, s;
            inv = 0;
            for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ rl8(inv, 1) ^ rl8(inv, 2) ^ rl8(inv, 3) ^ rl8(inv, 4) ^ 8'h63;
            sb[x] = s;
        end
        chk("sbox_00", 64'(sb[0]), 64'h63);
        chk("sbox_53", 64'(sb[8'h53]), 64'hed);
        chk("model_1round", absorb(INIT, 8'h00, 1), 64'h76347F6F37C1D7AC);

        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        chk("rst_ready", 64'(msg_ready), 64'h1);
        chk("rst_valid", 64'(digest_valid), 64'h0);
        chk("rst_digest", digest, 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        @(posedge clk); #1;

        // "abc" with back-pressure, then the identical message again
        q = {8'h61, 8'h62, 8'h63};
        foreach (q[i]) send(q[i], i == 2);
        get_digest(10, d1, t);
        chk("abc_latency", 64'(t), 64'(LAT));
        chk("abc_digest", d1, fold(q));
        foreach (q[i]) send(q[i], i == 2);
        get_digest(0, d2, t);
        chk("abc_repeat", d2, d1);

        for (int n = 0; n < 12; n++) begin
            len = $urandom_range(1, 4);
            q = {};
            for (int i = 0; i < len; i++) begin
                q.push_back(8'($urandom));
                send(q[i], i == len - 1);
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
            get_digest($urandom_range(0, 3), d1, t);
            chk("rand_digest", d1, fold(q));
        end

        // reset pulse during round 17 of byte 2
        send(8'h11, 0);
        send(8'h22, 1);
        repeat (16) begin @(posedge clk); #1; end
        rst_n = 0;
        @(negedge clk);
        chk("midrst_ready", 64'(msg_ready), 64'h1);
        chk("midrst_valid", 64'(digest_valid), 64'h0);
        chk("midrst_digest", digest, 64'h0);
        chk("midrst_busy", 64'(busy), 64'h0);
        @(posedge clk); #1 rst_n = 1;

        v1 = 1; b1 = 8'h00; l1 = 1; t = 0;
        do begin @(negedge clk); d1 = 64'(rdy1); @(posedge clk); #1; t++; end while (d1 == 0 && t < 50);
        chk("r1_accept", d1, 64'h1);
        v1 = 0;
        @(negedge clk);
        chk("r1_round_ready", 64'(rdy1), 64'h0);
        chk("r1_round_valid", 64'(dv1), 64'h0);
        chk("r1_round_busy", 64'(busy1), 64'h1);
        chk("r1_round_digest", dig1, 64'h0);
        @(posedge clk); #1; @(negedge clk);
        chk("r1_valid", 64'(dv1), 64'h1);
        chk("r1_digest", dig1, absorb(INIT, 8'h00, R1));
`ifndef LH_TWO_ROUNDS_EN
        chk("r1_literal", dig1, 64'h76347F6F37C1D7AC);
`endif
        dr1 = 1;
        @(posedge clk); #1 dr1 = 0;
        @(negedge clk);
        chk("r1_idle_ready", 64'(rdy1), 64'h1);
        chk("r1_idle_valid", 64'(dv1), 64'h0);
        chk("r1_idle_busy", 64'(busy1), 64'h0);
        chk("r1_idle_digest", dig1, 64'h0);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
